usb_tx_arbiter: RTL

//  Shares the single to-USB byte stream among NUM_REQ byte producers (JTAG TDO readback,

---
 rtl/usb_tx_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: shares one to-USB byte stream among NUM_REQ producers.
// Round-robin grant with message locking, burst and idle-timeout release,
// and a one-deep registered output stage.
// Optional feature macro: USB_TX_ARB_STATS_EN (per-requester byte counters on stats_o).
module usb_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned IDLE_TIMEOUT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [8*NUM_REQ-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    input  logic [NUM_REQ-1:0]    req_last_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    output logic [7:0]            to_usb_data_o,
    output logic                  to_usb_valid_o,
    input  logic                  to_usb_ready_i,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic [16*NUM_REQ-1:0] stats_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] TMO_MAX   = CNT_W'(IDLE_TIMEOUT);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q,  gidx_d;
    logic [IDX_W-1:0]   rr_q,    rr_d;
    logic [CNT_W-1:0]   burst_q, burst_d;
    logic [CNT_W-1:0]   tmo_q,   tmo_d;
    logic [7:0]         data_q,  data_d;
    logic               valid_q, valid_d;

    logic               out_free_c;
    logic               acc_c;
    logic               g_valid_c;
    logic               g_last_c;
    logic [7:0]         g_data_c;
    logic               pick_found_c;
    logic [IDX_W-1:0]   pick_idx_c;

    // Round-robin pick: first valid index strictly after rr_q, wrapping
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k] && (k <= int'(rr_q))) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IDX_W'(k);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k] && (k > int'(rr_q))) begin
                pick_found_c = 1'b1;
                pick_idx_c   = IDX_W'(k);
            end
        end
    end

    // Mux the granted requester's byte, valid and last flag
    always_comb begin
        g_valid_c = 1'b0;
        g_last_c  = 1'b0;
        g_data_c  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gidx_q == IDX_W'(k)) begin
                g_valid_c = req_valid_i[k];
                g_last_c  = req_last_i[k];
                g_data_c  = req_data_i[8*k +: 8];
            end
        end
    end

    // Ready depends only on state, grant and output-stage room, never on valid
    always_comb begin
        out_free_c  = !valid_q || to_usb_ready_i;
        req_ready_o = ((state_q == ST_GRANT) && out_free_c) ? grant_q : '0;
        acc_c       = (state_q == ST_GRANT) && g_valid_c && out_free_c;
    end

    // Next-state: grant selection, release conditions, counters, output stage
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found_c) begin
                    state_d             = ST_GRANT;
                    grant_d             = '0;
                    grant_d[pick_idx_c] = 1'b1;
                    gidx_d              = pick_idx_c;
                    burst_d             = '0;
                    tmo_d               = '0;
                end
            end
            ST_GRANT: begin
                if (acc_c) begin
                    burst_d = burst_q + CNT_W'(1);
                end
                if (g_valid_c) begin
                    tmo_d = '0;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
                if ((acc_c && (g_last_c || (burst_d == BURST_MAX))) ||
                    (!g_valid_c && (tmo_d == TMO_MAX))) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    rr_d    = gidx_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (acc_c) begin
            data_d  = g_data_c;
            valid_d = 1'b1;
        end else if (to_usb_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= IDX_W'(NUM_REQ - 1);
            burst_q <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign grant_o        = grant_q;
    assign to_usb_data_o  = data_q;
    assign to_usb_valid_o = valid_q;

`ifdef USB_TX_ARB_STATS_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
        logic [15:0] cnt_q, cnt_d;

        // Saturating count of bytes accepted from requester k
        always_comb begin
            cnt_d = cnt_q;
            if (acc_c && (gidx_q == IDX_W'(k)) && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        // Counter register, cleared only by reset
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign stats_o[16*k +: 16] = cnt_q;
    end
`else
    assign stats_o = '0;
`endif

endmodule
